// File: rtl/sched_pkg.sv
// Shared state encoding, default widths and sizing helpers for the job scheduler.
package sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  localparam int DEF_DW      = 16;
  localparam int DEF_KW      = 8;
  localparam int DEF_TIMEOUT = 63;

  // Counter width able to hold the timeout value itself.
  function automatic int tcnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, with wrap.
module rr_arbiter import sched_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int PW    = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic [PW-1:0]    idx
);

  logic hit_s;
  int   pos_s;

  // Scan offsets from farthest to nearest so the nearest hit after ptr wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    hit_s = 1'b0;
    pos_s = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos_s = (int'(ptr) + k) % N_REQ;
      hit_s = req[PW'(pos_s)];
      grant = hit_s ? (N_REQ'(1'b1) << PW'(pos_s)) : grant;
      valid = valid | hit_s;
      idx   = hit_s ? PW'(pos_s) : idx;
    end
  end

endmodule

// File: rtl/core_job_scheduler.sv
// Shares one compute core among N_REQ requesters: round-robin pick, operand
// latch, clear/start/wait sequencing with timeout, and a one-cycle done pulse.
module core_job_scheduler import sched_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int DW      = DEF_DW,
  parameter int KW      = DEF_KW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] a_in,
  input  logic [N_REQ*DW-1:0] b_in,
  input  logic [N_REQ*DW-1:0] c_in,
  input  logic [N_REQ*KW-1:0] k_in,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [DW-1:0]       result_out,
  output logic                err,
  output logic                busy,
  output logic [DW-1:0]       core_a,
  output logic [DW-1:0]       core_b,
  output logic [DW-1:0]       core_c,
  output logic [KW-1:0]       core_k,
  output logic                core_inicio,
  output logic                core_rst,
  input  logic                core_pronto,
  input  logic [DW-1:0]       core_resultado
);

  localparam int PW = idx_width(N_REQ);
  localparam int TW = tcnt_width(TIMEOUT);
  localparam logic [TW-1:0] TIMEOUT_C = TW'(TIMEOUT);

  state_t           state_r, state_s;
  logic [PW-1:0]    ptr_r, win_r, arb_idx_s;
  logic [N_REQ-1:0] arb_gnt_s;
  logic             arb_valid_s;
  logic [TW-1:0]    cnt_r;
  logic [DW-1:0]    sel_a_s, sel_b_s, sel_c_s;
  logic [KW-1:0]    sel_k_s;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr_r),
    .grant (arb_gnt_s),
    .valid (arb_valid_s),
    .idx   (arb_idx_s)
  );

  // Next-state logic; pronto is checked before the timeout so it wins a tie.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:  if (arb_valid_s) state_s = ST_LOAD; else state_s = ST_IDLE;
      ST_LOAD:  state_s = ST_START;
      ST_START: state_s = ST_WAIT;
      ST_WAIT:  if (core_pronto || (cnt_r == TIMEOUT_C)) state_s = ST_RESP;
                else state_s = ST_WAIT;
      ST_RESP:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Operand mux selecting the arbitration winner's slot.
  always_comb begin
    sel_a_s = '0;
    sel_b_s = '0;
    sel_c_s = '0;
    sel_k_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a_s = (arb_idx_s == PW'(i)) ? a_in[i*DW +: DW] : sel_a_s;
      sel_b_s = (arb_idx_s == PW'(i)) ? b_in[i*DW +: DW] : sel_b_s;
      sel_c_s = (arb_idx_s == PW'(i)) ? c_in[i*DW +: DW] : sel_c_s;
      sel_k_s = (arb_idx_s == PW'(i)) ? k_in[i*KW +: KW] : sel_k_s;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Winner index, round-robin pointer (advanced as RESP exits) and WAIT counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_r <= '0;
      win_r <= '0;
      cnt_r <= '0;
    end else begin
      if (state_s == ST_LOAD) win_r <= arb_idx_s;
      if (state_r == ST_RESP) ptr_r <= PW'((int'(win_r) + 1) % N_REQ);
      if (state_s == ST_LOAD) cnt_r <= '0;
      else if ((state_r == ST_WAIT) && (state_s == ST_WAIT)) cnt_r <= cnt_r + TW'(1);
    end
  end

  // Control outputs registered against the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      core_rst    <= 1'b0;
      core_inicio <= 1'b0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
    end else begin
      busy        <= (state_s != ST_IDLE);
      core_rst    <= (state_s == ST_LOAD) || (state_s == ST_RESP);
      core_inicio <= (state_s == ST_START) || (state_s == ST_WAIT);
      if (state_s == ST_LOAD)      gnt <= arb_gnt_s;
      else if (state_s == ST_IDLE) gnt <= '0;
      done        <= (state_s == ST_RESP) ? gnt : '0;
      err         <= (state_s == ST_RESP) && !core_pronto;
    end
  end

  // Operand latch on entry to LOAD; result capture (zero on timeout) on entry to RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_a     <= '0;
      core_b     <= '0;
      core_c     <= '0;
      core_k     <= '0;
      result_out <= '0;
    end else begin
      if (state_s == ST_LOAD) begin
        core_a <= sel_a_s;
        core_b <= sel_b_s;
        core_c <= sel_c_s;
        core_k <= sel_k_s;
      end
      if (state_s == ST_RESP) result_out <= core_pronto ? core_resultado : '0;
    end
  end

endmodule

// File: tb/tb_core_job_scheduler.sv
// Self-checking bench: stub core, event-level reference model, directed and random jobs.
module tb_core_job_scheduler;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int KW = 8;
  localparam int TO = 63;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] a_in, b_in, c_in;
  logic [N*KW-1:0] k_in;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   result_out, core_a, core_b, core_c, core_resultado;
  logic [KW-1:0]   core_k;
  logic            err, busy, core_inicio, core_rst, core_pronto;

  int checks = 0;
  int fails  = 0;

  core_job_scheduler #(.N_REQ(N), .DW(DW), .KW(KW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .c_in(c_in), .k_in(k_in),
    .gnt(gnt), .done(done), .result_out(result_out), .err(err), .busy(busy),
    .core_a(core_a), .core_b(core_b), .core_c(core_c), .core_k(core_k),
    .core_inicio(core_inicio), .core_rst(core_rst),
    .core_pronto(core_pronto), .core_resultado(core_resultado)
  );

  always #5 clk = ~clk;

  // Stub core: pronto rises L cycles after it first sees inicio, held while inicio.
  int lat_sel = 3;
  int job_lat = 3;
  int st_cnt  = 0;
  assign core_resultado = core_a + core_b + core_c + DW'(core_k);
  always @(posedge clk) begin
    if (core_rst || !core_inicio) begin
      st_cnt      <= 0;
      core_pronto <= 1'b0;
    end else begin
      st_cnt      <= st_cnt + 1;
      core_pronto <= (st_cnt >= job_lat);
    end
  end

  // Reference model: per job, LOAD cycle s, RESP cycle s+3+min(L,TO).
  int            cyc = 0, m_s = 0, m_resp = 0, m_win = 0, m_rr = 0;
  bit            m_act = 1'b0, m_to = 1'b0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_c = '0, m_res_job = '0, m_res_hold = '0;
  logic [KW-1:0] m_k = '0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      cyc = 0; m_act = 1'b0; m_rr = 0; m_res_hold = '0;
      m_a = '0; m_b = '0; m_c = '0; m_k = '0;
    end else begin
      if ((!m_act || cyc > m_resp) && req != '0) begin
        m_win = -1;
        for (int k = 0; k < N; k++) begin
          if (m_win < 0 && (req & (N'(1) << ((m_rr + k) % N))) != '0) m_win = (m_rr + k) % N;
        end
        m_s     = cyc + 1;
        job_lat = lat_sel;
        m_to    = (lat_sel > TO);
        m_resp  = m_s + 3 + (m_to ? TO : lat_sel);
        m_a = DW'(a_in >> (m_win * DW));
        m_b = DW'(b_in >> (m_win * DW));
        m_c = DW'(c_in >> (m_win * DW));
        m_k = KW'(k_in >> (m_win * KW));
        m_res_job = m_to ? '0 : (m_a + m_b + m_c + DW'(m_k));
        m_rr  = (m_win + 1) % N;
        m_act = 1'b1;
      end
      cyc = cyc + 1;
      if (m_act && cyc == m_resp) m_res_hold = m_res_job;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  initial forever begin
    logic [N-1:0]  e_gnt, e_done;
    logic          e_busy, e_err, e_ini, e_crst;
    logic [DW-1:0] e_res, e_a, e_b, e_c;
    logic [KW-1:0] e_k;
    @(negedge clk);
    if (rst) begin
      e_gnt = '0; e_done = '0; e_busy = 1'b0; e_err = 1'b0; e_ini = 1'b0; e_crst = 1'b0;
      e_res = '0; e_a = '0; e_b = '0; e_c = '0; e_k = '0;
    end else begin
      e_busy = m_act && cyc >= m_s && cyc <= m_resp;
      e_gnt  = e_busy ? (N'(1) << m_win) : '0;
      e_done = (m_act && cyc == m_resp) ? (N'(1) << m_win) : '0;
      e_err  = m_act && cyc == m_resp && m_to;
      e_ini  = m_act && cyc >= m_s + 1 && cyc <= m_resp - 1;
      e_crst = m_act && (cyc == m_s || cyc == m_resp);
      e_res = m_res_hold; e_a = m_a; e_b = m_b; e_c = m_c; e_k = m_k;
    end
    checks++;
    if ({gnt, done, busy, err, core_inicio, core_rst, result_out, core_a, core_b, core_c, core_k} !==
        {e_gnt, e_done, e_busy, e_err, e_ini, e_crst, e_res, e_a, e_b, e_c, e_k}) begin
      fails++;
      $display("FAIL cycle_cmp t=%0t got gnt=%b done=%b busy=%b err=%b ini=%b crst=%b res=%0d ops=%0d/%0d/%0d/%0d want gnt=%b done=%b busy=%b err=%b ini=%b crst=%b res=%0d ops=%0d/%0d/%0d/%0d",
               $time, gnt, done, busy, err, core_inicio, core_rst, result_out, core_a, core_b, core_c, core_k,
               e_gnt, e_done, e_busy, e_err, e_ini, e_crst, e_res, e_a, e_b, e_c, e_k);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N*DW-1:0] put_dw(input logic [N*DW-1:0] v, input int i, input logic [DW-1:0] x);
    logic [N*DW-1:0] m;
    m = {{(N*DW-DW){1'b0}}, {DW{1'b1}}} << (i * DW);
    return (v & ~m) | ((N*DW)'(x) << (i * DW));
  endfunction

  function automatic logic [N*KW-1:0] put_kw(input logic [N*KW-1:0] v, input int i, input logic [KW-1:0] x);
    logic [N*KW-1:0] m;
    m = {{(N*KW-KW){1'b0}}, {KW{1'b1}}} << (i * KW);
    return (v & ~m) | ((N*KW)'(x) << (i * KW));
  endfunction

  task automatic set_ops(input int i, input int a, input int b, input int c, input int k);
    a_in = put_dw(a_in, i, DW'(a));
    b_in = put_dw(b_in, i, DW'(b));
    c_in = put_dw(c_in, i, DW'(c));
    k_in = put_kw(k_in, i, KW'(k));
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (r < 0 && (v & (N'(1) << i)) != '0) r = i;
    return r;
  endfunction

  // Counts edges until done[idx] is seen; ends on the negedge inside RESP.
  task automatic wait_done(input int idx, input int budget, output int edges);
    bit ok = 1'b0;
    edges = 0;
    while (!ok && edges < budget) begin
      @(posedge clk); edges++;
      @(negedge clk); ok = ((done & (N'(1) << idx)) != '0);
    end
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL wait_done: no done[%0d] within %0d edges", idx, budget);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1; req = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
  endtask

  int e, n, idle_cnt, guard, jobs;
  int ord[5];
  int res[5];
  logic [N-1:0] d;

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; c_in = '0; k_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {gnt, done, busy, err, core_inicio, core_rst}, 64'd0);
    chk("reset_data", {result_out, core_a, core_k}, 64'd0);
    rst = 1'b0;

    // Single job on requester 0.
    @(posedge clk); #1 set_ops(0, 3, 4, 6, 8); lat_sel = 3; req = 4'b0001;
    wait_done(0, 20, e);
    chk("single_latency", e, 64'd7);
    chk("single_gnt", gnt, 64'd1);
    chk("single_result", result_out, 64'd21);
    chk("single_err", err, 64'd0);
    @(posedge clk); #1 req = '0;

    // Operand change after LOAD is ignored.
    @(posedge clk); #1 req = 4'b0001;
    repeat (4) @(posedge clk);
    #1 set_ops(0, 100, 4, 6, 8);
    wait_done(0, 20, e);
    chk("latched_result", result_out, 64'd21);
    @(posedge clk); #1 req = '0;

    // Contention from a fresh pointer: order 0,1,2,3,0 with one idle cycle between jobs.
    do_reset();
    for (int i = 0; i < N; i++) set_ops(i, i, 1, 1, 1);
    lat_sel = 3;
    @(posedge clk); #1 req = 4'b1111;
    n = 0; idle_cnt = 0; guard = 0;
    while (n < 5 && guard < 200) begin
      @(posedge clk); @(negedge clk); guard++;
      if (!busy) idle_cnt++;
      if (done != '0) begin
        ord[n] = onehot_idx(done);
        res[n] = int'(result_out);
        if (n > 0) chk("contention_gap", idle_cnt, 64'd1);
        idle_cnt = 0;
        n++;
      end
    end
    @(posedge clk); #1 req = '0;
    chk("contention_jobs", n, 64'd5);
    chk("order0", ord[0], 64'd0); chk("order1", ord[1], 64'd1); chk("order2", ord[2], 64'd2);
    chk("order3", ord[3], 64'd3); chk("order4", ord[4], 64'd0);
    chk("res0", res[0], 64'd3); chk("res1", res[1], 64'd4);
    chk("res2", res[2], 64'd5); chk("res3", res[3], 64'd6);

    // Timeout on requester 1, then a normal job on requester 2.
    @(posedge clk); #1 lat_sel = 1000; req = 4'b0010;
    wait_done(1, 100, e);
    chk("timeout_latency", e, 64'd67);
    chk("timeout_err", err, 64'd1);
    chk("timeout_result", result_out, 64'd0);
    chk("timeout_core_rst", core_rst, 64'd1);
    @(posedge clk); #1 lat_sel = 3; req = 4'b0100;
    wait_done(2, 20, e);
    chk("after_timeout_result", result_out, 64'd5);
    chk("after_timeout_err", err, 64'd0);
    @(posedge clk); #1 req = '0;

    // Pronto on exactly the timeout cycle wins.
    @(posedge clk); #1 lat_sel = TO; req = 4'b0001;
    wait_done(0, 100, e);
    chk("tie_latency", e, 64'd67);
    chk("tie_err", err, 64'd0);
    chk("tie_result", result_out, 64'd3);
    @(posedge clk); #1 req = '0;

    // Asynchronous reset during WAIT, then service from IDLE.
    @(posedge clk); #1 lat_sel = 1000; req = 4'b0001;
    repeat (8) @(posedge clk);
    #1 chk("busy_before_reset", {busy, core_inicio}, 64'd3);
    rst = 1'b1;
    #1 chk("async_reset_ctrl", {gnt, done, busy, err, core_inicio, core_rst}, 64'd0);
    chk("async_reset_data", {result_out, core_a, core_k}, 64'd0);
    req = '0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0; lat_sel = 2; req = 4'b0100;
    wait_done(2, 30, e);
    chk("post_reset_latency", e, 64'd6);
    chk("post_reset_result", result_out, 64'd5);
    @(posedge clk); #1 req = '0;

    // Randomized traffic checked cycle by cycle against the model.
    jobs = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); d = done;
      if (done != '0) jobs++;
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if ((d & (N'(1) << i)) != '0) req = req & ~(N'(1) << i);
        else if ((req & (N'(1) << i)) == '0) begin
          if ($urandom_range(0, 5) == 0) req = req | (N'(1) << i);
        end else if ($urandom_range(0, 299) == 0) req = req & ~(N'(1) << i);
      end
      if ($urandom_range(0, 3) == 0) begin
        a_in = {$urandom, $urandom}; b_in = {$urandom, $urandom};
        c_in = {$urandom, $urandom}; k_in = $urandom;
      end
      lat_sel = ($urandom_range(0, 3) == 0) ? int'($urandom_range(58, 70)) : int'($urandom_range(0, 8));
    end
    req = '0;
    repeat (100) @(posedge clk);
    chk("random_jobs_seen", (jobs > 20) ? 64'd1 : 64'd0, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/core_job_scheduler.md
Name: core_job_scheduler

Overview:
- Shares one projetoFinal compute core (operands A, B, C, K; start `inicio`; outputs `pronto`, `resultado`) among N requesters.
- Arbitrates round-robin and latches the winner's operands. Sequences the core through clear, start and wait-for-done, then returns the result to the winner with a one-cycle done pulse.
- Guards against a hung core with a timeout.
- Sits between the system-level requesters and the single core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DW, 16, width of A/B/C and of the result.
- KW, 8, width of K.
- TIMEOUT, 63, max cycles in WAIT before abort (1..255).

Ports:
- clk  in  1  system clock; rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request level; held until the matching done.
- a_in  in  N_REQ*DW  packed A operands; slot i at [i*DW +: DW].
- b_in  in  N_REQ*DW  packed B operands.
- c_in  in  N_REQ*DW  packed C operands.
- k_in  in  N_REQ*KW  packed K operands.
- gnt  out  N_REQ  one-hot; winner's bit high from LOAD through RESP.
- done  out  N_REQ  one-hot, one-cycle pulse in RESP.
- result_out  out  DW  result; valid while any done bit is high, held afterwards.
- err  out  1  high with done when the job timed out.
- busy  out  1  high whenever state is not IDLE.
- core_a, core_b, core_c  out  DW  latched operands to the core.
- core_k  out  KW  latched K to the core.
- core_inicio  out  1  core start level.
- core_rst  out  1  core clear pulse.
- core_pronto  in  1  core done.
- core_resultado  in  DW  core result.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr pointer=0.
- All outputs 0 during reset: gnt, done, result_out, err, busy, core_a/b/c/k, core_inicio, core_rst.
- States: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE.
- IDLE: if req != 0, pick the first set bit at or after the rr pointer, with wrap-around; go to LOAD next edge.
- LOAD (1 cycle):
  - latch the winner's a/b/c/k into the core_* registers;
  - set gnt one-hot;
  - core_rst=1 this cycle only;
  - clear the timeout counter.
- START (1 cycle): core_rst=0, core_inicio=1.
- WAIT:
  - core_inicio stays 1 and the counter increments each cycle.
  - If core_pronto=1: capture core_resultado into result_out, err=0, go to RESP.
  - Else if the counter equals TIMEOUT: result_out=0, err=1, core_inicio=0, go to RESP.
  - If pronto arrives in the same cycle as timeout, pronto wins (err=0).
- RESP (1 cycle):
  - core_inicio=0;
  - done[winner]=1;
  - core_rst=1 to clear a possibly hung core;
  - rr pointer = winner+1 mod N_REQ;
  - gnt clears on exit; next state IDLE.
- Latency:
  - req in IDLE to core_inicio rising: 2 edges.
  - core_pronto seen to done pulse: 1 edge.
  - Minimum job = 4 cycles plus core latency.
  - Back-to-back jobs: 1 idle cycle between RESP and the next LOAD.
- Operand stability: operands are sampled only in LOAD; requester changes afterwards are ignored.
- req dropped mid-job: the job completes and done still pulses. A requester that is no longer requesting ignores it.
- Simultaneous requests: strictly round-robin; no starvation. Worst-case wait = (N_REQ-1) jobs.
- core_pronto while not in WAIT: ignored.
- rst mid-operation: immediate return to IDLE with all outputs 0; no done pulse for the aborted job.
- N_REQ=1: the arbiter degenerates; the pointer stays 0.

Decomposition:
- Shared package `sched_pkg`:
  - state encoding constants (IDLE=0, LOAD=1, START=2, WAIT=3, RESP=4, 3-bit);
  - default DW/KW;
  - timeout counter width = clog2(TIMEOUT+1).
- One sub-module: `rr_arbiter` (N_REQ param; inputs req, ptr; outputs one-hot grant, valid, grant index). It is purely combinational.
- The FSM, counters and operand registers stay in the top module.

Test Plan:
- Bench uses a stub core: after core_inicio rises it asserts pronto after L cycles with resultado = A+B+C+K. pronto stays high while inicio is high; core_rst clears it.
- Single job: req=0001; A=3, B=4, C=6, K=8; L=3.
  - Expect gnt=0001.
  - Expect done[0] exactly 7 cycles after req.
  - Expect result_out=21, err=0.
- Contention: req=1111 held; all slots A=i, B=C=K=1.
  - Expect done order 0,1,2,3,0.
  - Expect results 3,4,5,6.
  - Expect exactly 1 idle cycle between jobs.
- Timeout: the stub never asserts pronto; TIMEOUT=63; req=0010.
  - Expect done[1] with err=1 and result_out=0.
  - Expect core_rst pulse in RESP.
  - A following job on requester 2 completes normally.
- Pronto on the timeout cycle: set L so pronto arrives exactly when the counter reaches TIMEOUT.
  - Expect err=0 and a valid result.
- Reset mid-job: assert rst during WAIT.
  - Expect all outputs 0 asynchronously and no done pulse.
  - After release, req=0100 is served from IDLE.
- Operand change after LOAD: change a_in[0] to 100 during WAIT.
  - Result still uses the latched A=3, giving 21.
